gen_linear_part_seq: RTL and testbench

Sequential linear (XOR) recombination stage for the decomposed carry-lookahead adder. It is the consumer of the non-linear product-term vector that the non-linear part generates. It accepts those terms as a serial, lane-parallel stream under valid/ready, XOR-accumulates them per carry group, and combines the carries with the linear terms a^b. It returns the NBIT-bit sum plus carry-out on an output valid/ready handshake.

---
 rtl/gen_linear_part_seq_pkg.sv | 22 ++
 rtl/gen_term_group_map.sv | 21 ++
 rtl/gen_linear_part_seq.sv | 111 +++++++++++
 tb/tb_gen_linear_part_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_linear_part_seq_pkg.sv
// Shared constants for the decomposed carry-lookahead adder: operand width,
// non-linear term count, carry-group layout and recombination FSM encoding.
package gen_linear_part_seq_pkg;

    localparam int NBIT = 4;
    localparam int NNL  = (1 << (NBIT + 1)) - NBIT - 2;
    localparam int GW   = (NBIT > 1) ? $clog2(NBIT) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    // Group j holds the terms whose XOR is carry c[j+1].
    function automatic int grp_base(input int j);
        return (1 << (j + 1)) - j - 2;
    endfunction

    function automatic int grp_size(input int j);
        return (1 << (j + 1)) - 1;
    endfunction

endpackage

// File: rtl/gen_term_group_map.sv
// Maps a flat non-linear term index to its carry group, and flags
// indices past the end of the term vector (padding lanes on the last beat).
module gen_term_group_map
    import gen_linear_part_seq_pkg::*;
#(
    parameter int IDXW = 5
) (
    input  logic [IDXW-1:0] idx,
    output logic [GW-1:0]   grp,
    output logic            vld
);

    always_comb begin
        grp = '0;
        for (int j = 1; j < NBIT; j++) begin
            if (int'(idx) >= grp_base(j)) grp = GW'(j);
        end
        vld = int'(idx) < (grp_base(NBIT - 1) + grp_size(NBIT - 1));
    end

endmodule

// File: rtl/gen_linear_part_seq.sv
// Linear recombination stage: XOR-accumulates a lane-parallel stream of
// non-linear terms into per-group carries and forms sum = a ^ b ^ c.
module gen_linear_part_seq
    import gen_linear_part_seq_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_terms,
    input  logic             in_last,
    input  logic [NBIT-1:0]  a,
    input  logic [NBIT-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBIT-1:0]  sum,
    output logic             cout,
    output logic             err
);

    localparam int NBEAT = (NNL + LANES - 1) / LANES;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int IDXW  = (NBEAT * LANES > 1) ? $clog2(NBEAT * LANES) : 1;

    logic [1:0]                  state;
    logic [CW-1:0]               cnt;
    logic [NBIT-1:0]             acc, a_q, b_q;
    logic                        err_acc, rdy_q;

    logic [LANES-1:0][IDXW-1:0]  lane_idx;
    logic [LANES-1:0][GW-1:0]    lane_grp;
    logic [LANES-1:0]            lane_vld;
    logic [NBIT-1:0]             beat_x, acc_nxt, a_s, b_s, sum_nxt;
    logic [NBIT:0]               c;
    logic                        first, last_beat, accept, err_nxt;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gen_term_group_map #(.IDXW(IDXW)) u_map (
            .idx (lane_idx[l]),
            .grp (lane_grp[l]),
            .vld (lane_vld[l])
        );
    end

    assign out_valid = (state == DONE);
    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = rdy_q && (state != DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        first     = (state == IDLE);
        last_beat = (cnt == CW'(NBEAT - 1));
        beat_x    = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = IDXW'(cnt) * IDXW'(LANES) + IDXW'(l);
            for (int g = 0; g < NBIT; g++) begin
                if (lane_vld[l] && lane_grp[l] == GW'(g)) beat_x[g] = beat_x[g] ^ in_terms[l];
            end
        end
        // The first beat of a frame both clears and loads the accumulators.
        acc_nxt = (first ? '0 : acc) ^ beat_x;
        a_s     = first ? a : a_q;
        b_s     = first ? b : b_q;
        c       = {acc_nxt, 1'b0};
        sum_nxt = a_s ^ b_s ^ c[NBIT-1:0];
        err_nxt = (first ? 1'b0 : err_acc) | (in_last != last_beat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_acc <= 1'b0;
            rdy_q   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        acc     <= acc_nxt;
                        err_acc <= err_nxt;
                        cnt     <= last_beat ? '0 : cnt + CW'(1);
                        if (first) begin
                            a_q <= a;
                            b_q <= b;
                        end
                        if (last_beat) begin
                            state <= DONE;
                            sum   <= sum_nxt;
                            cout  <= c[NBIT];
                            err   <= err_nxt;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                DONE:    if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_linear_part_seq.sv
// Scoreboard bench for gen_linear_part_seq: 4-lane build for framing/handshake
// scenarios, 1-lane and full-width builds for exhaustive sums.
module tb_gen_linear_part_seq;
    import gen_linear_part_seq_pkg::NBIT;

    localparam int TNNL = (1 << (NBIT + 1)) - NBIT - 2;
    localparam int L4   = 4;
    localparam int NB4  = (TNNL + L4 - 1) / L4;

    typedef struct packed {
        logic [NBIT-1:0] sum;
        logic            cout;
        logic            err;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic            in_valid = 0, in_last = 0, out_ready = 0;
    logic [L4-1:0]   in_terms = '0;
    logic [NBIT-1:0] a = '0, b = '0;
    logic            in_ready, out_valid, cout, err;
    logic [NBIT-1:0] sum;

    logic            s_valid = 0, s_last = 0, s_oready = 0;
    logic [0:0]      s_terms = '0;
    logic [NBIT-1:0] s_a = '0, s_b = '0;
    logic            s_ready, s_ovalid, s_cout, s_err;
    logic [NBIT-1:0] s_sum;

    logic            w_valid = 0, w_last = 0, w_oready = 0;
    logic [TNNL-1:0] w_terms = '0;
    logic [NBIT-1:0] w_a = '0, w_b = '0;
    logic            w_ready, w_ovalid, w_cout, w_err;
    logic [NBIT-1:0] w_sum;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gen_linear_part_seq #(.LANES(L4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_terms(in_terms), .in_last(in_last), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .err(err)
    );

    gen_linear_part_seq #(.LANES(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
        .in_terms(s_terms), .in_last(s_last), .a(s_a), .b(s_b),
        .out_valid(s_ovalid), .out_ready(s_oready), .sum(s_sum), .cout(s_cout), .err(s_err)
    );

    gen_linear_part_seq #(.LANES(TNNL)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ready),
        .in_terms(w_terms), .in_last(w_last), .a(w_a), .b(w_b),
        .out_valid(w_ovalid), .out_ready(w_oready), .sum(w_sum), .cout(w_cout), .err(w_err)
    );

    // Reference producer: group j = {a_j&b_j, a_j&t, b_j&t for t in group j-1}.
    function automatic logic [TNNL-1:0] gen_terms(input logic [NBIT-1:0] av, input logic [NBIT-1:0] bv);
        logic [TNNL-1:0] t;
        int p, pb, psz, cur;
        t = '0; p = 0; pb = 0; psz = 0;
        for (int j = 0; j < NBIT; j++) begin
            cur = p;
            t[p] = av[j] & bv[j]; p++;
            for (int k = 0; k < psz; k++) begin t[p] = av[j] & t[pb + k]; p++; end
            for (int k = 0; k < psz; k++) begin t[p] = bv[j] & t[pb + k]; p++; end
            pb = cur;
            psz = 2 * psz + 1;
        end
        return t;
    endfunction

    function automatic res_t exp_res(input logic [NBIT-1:0] av, input logic [NBIT-1:0] bv, input logic e);
        logic [NBIT:0] s;
        res_t r;
        s = {1'b0, av} + {1'b0, bv};
        r.sum = s[NBIT-1:0];
        r.cout = s[NBIT];
        r.err = e;
        return r;
    endfunction

    task automatic send_beat(input int k, input logic [TNNL-1:0] t, input logic last);
        int w;
        in_valid = 1'b1;
        in_last = last;
        for (int l = 0; l < L4; l++)
            in_terms[l] = (k * L4 + l < TNNL) ? t[k * L4 + l] : 1'($urandom_range(0, 1));
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (w >= 200) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: beat %0d never accepted, in_ready=%b required 1", k, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [NBIT-1:0] av, input logic [NBIT-1:0] bv,
                               input int extra_last, input bit drop_last, input bit gaps);
        logic [TNNL-1:0] t;
        t = gen_terms(av, bv);
        for (int k = 0; k < NB4; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = (k == 0) ? av : NBIT'($urandom);
            b = (k == 0) ? bv : NBIT'($urandom);
            send_beat(k, t, ((k == NB4 - 1) && !drop_last) || (k == extra_last));
            checks++;
            if (out_valid !== (k == NB4 - 1)) begin
                errors++;
                $display("FAIL latency: after beat %0d out_valid=%b required %b", k, out_valid, k == NB4 - 1);
            end
        end
        exp_q.push_back(exp_res(av, bv, drop_last || (extra_last >= 0 && extra_last != NB4 - 1)));
    endtask

    task automatic get_result(input int hold);
        int w;
        res_t snap, e;
        w = 0;
        while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
        if (w >= 200) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        snap = {sum, cout, err};
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_terms = L4'($urandom);
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {sum, cout, err} !== snap) begin
                errors++;
                $display("FAIL hold: in_ready=%b out_valid=%b res=%h required 0 1 %h", in_ready, out_valid, {sum, cout, err}, snap);
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got result %h with no expected entry", {sum, cout, err});
        end else begin
            e = exp_q.pop_front();
            if ({sum, cout, err} !== e) begin
                errors++;
                $display("FAIL result: sum=%h cout=%b err=%b required sum=%h cout=%b err=%b", sum, cout, err, e.sum, e.cout, e.err);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s: in_ready=%b out_valid=%b sum=%h cout=%b err=%b required all 0", tag, in_ready, out_valid, sum, cout, err);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_vals("reset_values");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_vals("ready_before_edge");
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        drive_frame(4'd11, 4'd6, -1, 1'b0, 1'b0);
        get_result(0);
        drive_frame(4'd15, 4'd1, -1, 1'b0, 1'b0);
        get_result(0);
        drive_frame(4'd0, 4'd0, -1, 1'b0, 1'b0);
        get_result(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_frame(NBIT'($urandom), NBIT'($urandom), -1, 1'b0, 1'b0);
            get_result(0);
        end
    endtask

    task automatic test_stall();
        drive_frame(4'd7, 4'd13, -1, 1'b0, 1'b1);
        get_result(5);
        drive_frame(4'd12, 4'd5, -1, 1'b0, 1'b1);
        get_result(5);
    endtask

    task automatic test_framing();
        drive_frame(4'd3, 4'd14, 3, 1'b0, 1'b0);
        get_result(0);
        drive_frame(4'd10, 4'd10, -1, 1'b1, 1'b0);
        get_result(0);
    endtask

    task automatic test_reset_mid();
        logic [TNNL-1:0] t;
        t = gen_terms(4'd5, 4'd3);
        a = 4'd5; b = 4'd3;
        for (int k = 0; k <= 4; k++) send_beat(k, t, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_frame");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_frame(4'd9, 4'd7, -1, 1'b0, 1'b0);
        get_result(0);
    endtask

    task automatic test_exhaustive();
        logic [TNNL-1:0] t;
        res_t e;
        int w;
        for (int ai = 0; ai < (1 << NBIT); ai++) begin
            for (int bi = 0; bi < (1 << NBIT); bi++) begin
                t = gen_terms(NBIT'(ai), NBIT'(bi));
                exp_q.push_back(exp_res(NBIT'(ai), NBIT'(bi), 1'b0));
                w_a = NBIT'(ai); w_b = NBIT'(bi); w_terms = t; w_last = 1'b1; w_valid = 1'b1;
                w = 0;
                while (!w_ready && w < 50) begin @(posedge clk); #1; w++; end
                @(posedge clk); #1;
                w_valid = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if ({w_ovalid, w_sum, w_cout, w_err} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL wide_sum a=%0d b=%0d: valid=%b res=%h required 1 %h", ai, bi, w_ovalid, {w_sum, w_cout, w_err}, e);
                end
                w_oready = 1'b1;
                @(posedge clk); #1;
                w_oready = 1'b0;

                exp_q.push_back(exp_res(NBIT'(ai), NBIT'(bi), 1'b0));
                for (int k = 0; k < TNNL; k++) begin
                    s_a = (k == 0) ? NBIT'(ai) : NBIT'($urandom);
                    s_b = (k == 0) ? NBIT'(bi) : NBIT'($urandom);
                    s_terms[0] = t[k]; s_last = (k == TNNL - 1); s_valid = 1'b1;
                    w = 0;
                    while (!s_ready && w < 50) begin @(posedge clk); #1; w++; end
                    @(posedge clk); #1;
                end
                s_valid = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if ({s_ovalid, s_sum, s_cout, s_err} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL serial_sum a=%0d b=%0d: valid=%b res=%h required 1 %h", ai, bi, s_ovalid, {s_sum, s_cout, s_err}, e);
                end
                s_oready = 1'b1;
                @(posedge clk); #1;
                s_oready = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_framing();
        test_reset_mid();
        test_exhaustive();
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
